alu_stream: RTL and testbench
=============================

# alu_stream

Request/response wrapper that makes the combinational `alu` a flow-controlled, pipelined execution unit. Operand triples `{a, b, f}` arrive on a valid/ready request channel, are latched, evaluated by one internal `alu` instance, and returned in order with a caller tag on a valid/ready response channel. A 2-entry response FIFO absorbs downstream backpressure. The block sits between a sequencer (board input controller or CPU execute stage) and its result consumer.

## Interface
- `WIDTH`, 32, operand/result width; passed to the internal `alu`.
- `TAGW`, 4, width of the opaque request tag echoed on the response.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_a`  in  WIDTH  operand a.
- `req_b`  in  WIDTH  operand b (shift amount for f=5..7, low log2(WIDTH) bits).
- `req_f`  in  3  ALU function code, passed unchanged to `alu`.
- `req_tag`  in  TAGW  caller tag.
- `rsp_valid`  out  1  response present at FIFO head.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_y`  out  WIDTH  result `y` from `alu`.
- `rsp_t`  out  3  flags `t` from `alu`, unchanged.
- `rsp_tag`  out  TAGW  tag of the request that produced this response.
- `busy`  out  1  high when stage register or FIFO holds anything.
- `op_count`  out  32  present only with `ALU_OPCNT_EN` (see Configuration).

## Operation
- Stage S1: registers `a, b, f, tag` plus `s1_valid`. `alu` evaluates S1 contents combinationally.
- Stage S2: 2-entry FIFO of `{y, t, tag}`, head drives `rsp_*`; pointers wrap modulo 2, occupancy count 0..2.
- Request handshake: accept when `req_valid && req_ready`. Response handshake: pop when `rsp_valid && rsp_ready`.
- S1 moves (`s1_move`) when `s1_valid` and FIFO not full, or FIFO full and pop this cycle.
- `req_ready = !s1_valid || s1_move` (combinational dependency on `rsp_ready` through pop; intentional).
- On accept, S1 loads the request; if S1 moves without accept, `s1_valid` clears.
- Push and pop same cycle: occupancy unchanged, FIFO full case included.
- Pop on empty and push on full without pop never occur by construction.
- Responses strictly in request order; no reordering, no drops, no duplicates.
- Request fields sampled only on the accept edge; changes while `req_ready` low are ignored.
- `rsp_*` data stable while `rsp_valid && !rsp_ready`.
- `busy = s1_valid || (count != 0)`.
- Shift semantics come from `alu`: f=5 logical right, f=6 left, f=7 arithmetic right.

## Timing
- Reset: `s1_valid`=0, FIFO count=0, pointers=0, `rsp_valid`=0, `rsp_y`/`rsp_t`/`rsp_tag`=0, `busy`=0, `op_count`=0; `req_ready`=1 in first cycle after reset.
- `rst` mid-operation discards S1 and FIFO contents; no response emitted for in-flight requests.
- Latency: request accepted on edge k, with empty FIFO `rsp_valid` high after edge k+1.
- Throughput: one request per cycle while `rsp_ready` held high.
- With `rsp_ready` low: three requests accepted (2 in FIFO, 1 in S1), then `req_ready` low until a pop.

## Configuration
- `ALU_OPCNT_EN` defined: `op_count` port exists; 32-bit counter increments on each response pop, wraps 0xFFFFFFFF→0, cleared by `rst`.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then single request a=0xA9, b=4, f=5, tag=3 with `rsp_ready`=1 -> `rsp_valid` after 2 edges, `rsp_y`=0x0A, `rsp_tag`=3, `busy` returns 0.
- Back-to-back f=6 (a=0xA9,b=4) and f=7 (a=0xFFFFFFB0,b=8), tags 1,2 -> in-order responses 0xA90 then 0xFFFFFFFF, one per cycle.
- `rsp_ready`=0, stream 4 requests -> exactly 3 accepted, `req_ready` low; raise `rsp_ready` -> all 4 emerge in order, tags intact.
- FIFO full with simultaneous pop and S1 move -> count stays 2, no lost/duplicated response.
- Assert `rst` with 3 in flight -> next cycle `rsp_valid`=0, `busy`=0, `req_ready`=1; no stale responses later.
- With `ALU_OPCNT_EN`: 5 popped responses -> `op_count`=5; preload near wrap via 2^32 pops in formal/force -> 0.

Source files
------------

// File: rtl/alu_stream.sv
// alu_stream: valid/ready pipelined wrapper around a combinational alu with a 2-entry response FIFO.
// Optional op_count port/counter enabled by defining ALU_OPCNT_EN. alu flags t = {carry/borrow, negative, zero}.

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       t
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   sh;
    logic             cy;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        sh   = b[SHW-1:0];
        cy   = 1'b0;
        y    = '0;
        unique case (f)
            3'd0: begin y = sum[WIDTH-1:0];  cy = sum[WIDTH];  end
            3'd1: begin y = diff[WIDTH-1:0]; cy = diff[WIDTH]; end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = a >> sh;
            3'd6: y = a << sh;
            3'd7: y = $signed(a) >>> sh;
            default: y = '0;
        endcase
        t = {cy, y[WIDTH-1], (y == '0)};
    end
endmodule

module alu_stream #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_f,
    input  logic [TAGW-1:0]  req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [2:0]       rsp_t,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             busy
`ifdef ALU_OPCNT_EN
    ,
    output logic [31:0]      op_count
`endif
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       f_q, f_d;
    logic [TAGW-1:0]  tag_q, tag_d;

    logic [WIDTH-1:0] mem_y_q   [2];
    logic [WIDTH-1:0] mem_y_d   [2];
    logic [2:0]       mem_t_q   [2];
    logic [2:0]       mem_t_d   [2];
    logic [TAGW-1:0]  mem_tag_q [2];
    logic [TAGW-1:0]  mem_tag_d [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic [WIDTH-1:0] alu_y;
    logic [2:0]       alu_t;
    logic             full, pop, push, s1_move, accept;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a (a_q),
        .b (b_q),
        .f (f_q),
        .y (alu_y),
        .t (alu_t)
    );

    always_comb begin
        full      = (count_q == 2'd2);
        rsp_valid = (count_q != 2'd0);
        pop       = rsp_valid && rsp_ready;
        s1_move   = s1_valid_q && (!full || pop);
        push      = s1_move;
        req_ready = !s1_valid_q || s1_move;
        accept    = req_valid && req_ready;
        busy      = s1_valid_q || rsp_valid;

        // Data outputs are forced to zero while empty so reset state is clean without resetting storage.
        rsp_y   = rsp_valid ? mem_y_q[rd_ptr_q]   : '0;
        rsp_t   = rsp_valid ? mem_t_q[rd_ptr_q]   : '0;
        rsp_tag = rsp_valid ? mem_tag_q[rd_ptr_q] : '0;

        s1_valid_d = accept ? 1'b1 : (s1_move ? 1'b0 : s1_valid_q);
        a_d   = accept ? req_a   : a_q;
        b_d   = accept ? req_b   : b_q;
        f_d   = accept ? req_f   : f_q;
        tag_d = accept ? req_tag : tag_q;

        mem_y_d   = mem_y_q;
        mem_t_d   = mem_t_q;
        mem_tag_d = mem_tag_q;
        if (push) begin
            mem_y_d[wr_ptr_q]   = alu_y;
            mem_t_d[wr_ptr_q]   = alu_t;
            mem_tag_d[wr_ptr_q] = tag_q;
        end
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state: reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Datapath storage: no reset, qualified by the control state above
    always_ff @(posedge clk) begin
        a_q       <= a_d;
        b_q       <= b_d;
        f_q       <= f_d;
        tag_q     <= tag_d;
        mem_y_q   <= mem_y_d;
        mem_t_q   <= mem_t_d;
        mem_tag_q <= mem_tag_d;
    end

`ifdef ALU_OPCNT_EN
    logic [31:0] op_count_q, op_count_d;

    always_comb op_count_d = pop ? op_count_q + 32'd1 : op_count_q;

    always_ff @(posedge clk) begin
        if (rst) op_count_q <= 32'd0;
        else     op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: table-driven vectors plus backpressure/reset sequences, scoreboard checked at negedge.
// Compile with ALU_OPCNT_EN defined to also exercise op_count.

module tb_alu_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_f;
    logic [3:0]  req_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_y;
    logic [2:0]  rsp_t;
    logic [3:0]  rsp_tag;
    logic        busy;
`ifdef ALU_OPCNT_EN
    logic [31:0] op_count;
`endif

    alu_stream #(.WIDTH(32), .TAGW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_f     (req_f),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_t     (rsp_t),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
`ifdef ALU_OPCNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [3:0]  tag;
        logic [31:0] y;
        logic [2:0]  t;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic [2:0]  t;
        logic [3:0]  tag;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     pops_since_rst = 0;
    logic   hold_prev = 1'b0;
    logic [38:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: compare every response on the cycle it is popped.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev      = 1'b0;
            pops_since_rst = 0;
        end else begin
            if (hold_prev && rsp_valid)
                chk("rsp_stable", {rsp_y, rsp_t, rsp_tag}, held);
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp", {rsp_y, rsp_t, rsp_tag}, {e.y, e.t, e.tag});
                end
                pops_since_rst++;
            end
            hold_prev = rsp_valid && !rsp_ready;
            held      = {rsp_y, rsp_t, rsp_tag};
        end
    end

    task automatic send(input vec_t v, output int stalls);
        logic acc;
        exp_t e;
        req_a = v.a; req_b = v.b; req_f = v.f; req_tag = v.tag;
        req_valid = 1'b1;
        stalls = 0;
        acc = 1'b0;
        while (!acc && stalls < 50) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            if (!acc) stalls++;
        end
        if (acc) begin
            e.y = v.y; e.t = v.t; e.tag = v.tag;
            sb.push_back(e);
        end else begin
            chk("send_accept", acc, 1);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                input logic [3:0] tag, input logic [31:0] y, input logic [2:0] t);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.tag = tag; v.y = y; v.t = t;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        vec_t v;
        int   st, stall_sum, stale;

        // t = {carry/borrow, negative, zero}
        tbl[0]  = mk(32'h0000_00A9, 32'd4,        3'd5, 4'd3,  32'h0000_000A, 3'b000);
        tbl[1]  = mk(32'h0000_00A9, 32'd4,        3'd6, 4'd1,  32'h0000_0A90, 3'b000);
        tbl[2]  = mk(32'hFFFF_FFB0, 32'd8,        3'd7, 4'd2,  32'hFFFF_FFFF, 3'b010);
        tbl[3]  = mk(32'hFFFF_FFFF, 32'd1,        3'd0, 4'd4,  32'h0000_0000, 3'b101);
        tbl[4]  = mk(32'h0000_0005, 32'd7,        3'd1, 4'd5,  32'hFFFF_FFFE, 3'b110);
        tbl[5]  = mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 4'd6, 32'h00F0_00F0, 3'b000);
        tbl[6]  = mk(32'h1200_0000, 32'h0034_0000, 3'd3, 4'd7, 32'h1234_0000, 3'b000);
        tbl[7]  = mk(32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'd4, 4'd8, 32'h0000_0000, 3'b001);
        tbl[8]  = mk(32'h0000_0001, 32'h25,       3'd6, 4'd9,  32'h0000_0020, 3'b000);
        tbl[9]  = mk(32'h7000_0000, 32'd4,        3'd7, 4'd10, 32'h0700_0000, 3'b000);
        tbl[10] = mk(32'h8000_0000, 32'd31,       3'd5, 4'd11, 32'h0000_0001, 3'b000);
        tbl[11] = mk(32'h0000_0009, 32'd9,        3'd1, 4'd12, 32'h0000_0000, 3'b001);
        tbl[12] = mk(32'h7FFF_FFFF, 32'd1,        3'd0, 4'd13, 32'h8000_0000, 3'b010);

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_f = '0; req_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", {rsp_y, rsp_t, rsp_tag}, 0);
`ifdef ALU_OPCNT_EN
        chk("rst_op_count", op_count, 0);
`endif
        @(posedge clk); #1;

        // Single request: latency and busy return
        rsp_ready = 1'b1;
        send(tbl[0], st);
        @(negedge clk);
        chk("lat_s1_rsp_valid", rsp_valid, 0);
        chk("lat_s1_busy", busy, 1);
        @(negedge clk);
        chk("lat_rsp_valid", rsp_valid, 1);
        @(negedge clk);
        chk("lat_busy_idle", busy, 0);
        @(posedge clk); #1;

        // Back-to-back table with full throughput
        stall_sum = 0;
        for (int i = 1; i < 13; i++) begin
            send(tbl[i], st);
            stall_sum += st;
        end
        chk("throughput_stalls", stall_sum, 0);
        drain();

        // Backpressure: three accepted, fourth blocked
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = mk(32'd100 + i, 32'd5, 3'd0, 4'(i + 1), 32'd105 + i, 3'b000);
            send(v, st);
            chk("bp_accept_stall", st, 0);
        end
        req_a = 32'd200; req_b = 32'd3; req_f = 3'd0; req_tag = 4'd4;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_req_ready_low", req_ready, 0);
        end
        chk("bp_busy", busy, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_req_ready", req_ready, 1);
        @(posedge clk); #1;
        begin
            exp_t e;
            e.y = 32'd203; e.t = 3'b000; e.tag = 4'd4;
            sb.push_back(e);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("full_after_move_req_ready", req_ready, 0);
        chk("full_after_move_head_tag", rsp_tag, 2);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();

        // Reset with three requests in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = mk(32'hDEAD_0000 + i, 32'd0, 3'd3, 4'(i + 8), 32'hDEAD_0000 + i, 3'b010);
            send(v, st);
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("midrst_no_stale", stale, 0);
        @(posedge clk); #1;

        // Five pops after reset, also checks recovery
        for (int i = 0; i < 5; i++) begin
            v = mk(32'h0000_00F0, 32'(i), 3'd5, 4'(i), 32'h0000_00F0 >> i, 3'b000);
            send(v, st);
        end
        drain();
`ifdef ALU_OPCNT_EN
        chk("op_count", op_count, 5);
        chk("op_count_vs_pops", op_count, pops_since_rst);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
